// File: rtl/qspi_sram_target.sv
// Quad-SPI SRAM responder: oversamples SCK/SS_n/SIO in clk and serves 0x02 write / 0x03 read
// on a 2**ADDR_BITS byte array. Define QSPI_SRAM_TARGET_FAST_READ_EN to accept 0xEB fast read.
module qspi_sram_target #(
  parameter int ADDR_BITS    = 8,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ss_n,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic       sio_oe,
  output logic       busy
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int SH_W  = (ADDR_BITS > 8) ? ADDR_BITS : 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_IGNORE = 3'd5
`ifdef QSPI_SRAM_TARGET_FAST_READ_EN
    , ST_DUMMY = 3'd6
`endif
  } state_t;

  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
`ifdef QSPI_SRAM_TARGET_FAST_READ_EN
  localparam logic [1:0] OP_FRD = 2'd2;
  localparam int         DC_W   = $clog2(DUMMY_CYCLES + 1) + 1;
  logic [DC_W-1:0] dcnt_q, dcnt_d;
`endif

  logic       sck_s1_q, sck_s2_q, sck_s3_q;
  logic       sel_s1_q, sel_s2_q;
  logic [3:0] sio_s1_q, sio_s2_q;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [1:0]          op_q, op_d;
  logic                half_q, half_d;
  logic [3:0]          wr_hi_q, wr_hi_d;
  logic [3:0]          sio_out_q, sio_out_d;
  logic                sio_oe_q, sio_oe_d;

  logic [7:0]      mem [0:DEPTH-1];
  logic            rise_s, fall_s, mem_we_s;
  logic [7:0]      rd_byte_s, mem_wdata_s;
  logic [SH_W-1:0] shift_nxt_s;
  logic [ADDR_BITS-1:0] ptr_inc_s;

  // Two-flop synchronizers; sel is the inverted chip select so reset reads as deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_s3_q <= 1'b0;
      sel_s1_q <= 1'b0;
      sel_s2_q <= 1'b0;
      sio_s1_q <= 4'h0;
      sio_s2_q <= 4'h0;
    end else begin
      sck_s1_q <= sck;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      sel_s1_q <= ~ss_n;
      sel_s2_q <= sel_s1_q;
      sio_s1_q <= sio_in;
      sio_s2_q <= sio_s1_q;
    end
  end

  assign rise_s      = sck_s2_q & ~sck_s3_q;
  assign fall_s      = ~sck_s2_q & sck_s3_q;
  assign rd_byte_s   = mem[ptr_q];
  assign shift_nxt_s = {shift_q[SH_W-5:0], sio_s2_q};
  assign mem_wdata_s = {wr_hi_q, sio_s2_q};
  assign ptr_inc_s   = ptr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};

  // Next-state logic; any edge seen while deselected is dropped by the abort branch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    op_d      = op_q;
    half_d    = half_q;
    wr_hi_d   = wr_hi_q;
    sio_out_d = sio_out_q;
    sio_oe_d  = sio_oe_q;
    mem_we_s  = 1'b0;
`ifdef QSPI_SRAM_TARGET_FAST_READ_EN
    dcnt_d    = dcnt_q;
`endif
    if (!sel_s2_q) begin
      state_d   = ST_IDLE;
      cnt_d     = 3'd0;
      half_d    = 1'b0;
      sio_out_d = 4'h0;
      sio_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = 3'd0;
          half_d  = 1'b0;
        end
        ST_CMD: begin
          if (rise_s) begin
            shift_d = shift_nxt_s;
            if (cnt_q == 3'd1) begin
              cnt_d = 3'd0;
              case (shift_nxt_s[7:0])
                8'h02: begin state_d = ST_ADDR; op_d = OP_WR; end
                8'h03: begin state_d = ST_ADDR; op_d = OP_RD; end
`ifdef QSPI_SRAM_TARGET_FAST_READ_EN
                8'hEB: begin state_d = ST_ADDR; op_d = OP_FRD; end
`endif
                default: state_d = ST_IGNORE;
              endcase
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_ADDR: begin
          if (rise_s) begin
            shift_d = shift_nxt_s;
            if (cnt_q == 3'd5) begin
              cnt_d  = 3'd0;
              half_d = 1'b0;
              ptr_d  = shift_nxt_s[ADDR_BITS-1:0];
              case (op_q)
                OP_WR: state_d = ST_WRITE;
                OP_RD: state_d = ST_READ;
`ifdef QSPI_SRAM_TARGET_FAST_READ_EN
                OP_FRD: begin
                  state_d = (DUMMY_CYCLES == 0) ? ST_READ : ST_DUMMY;
                  dcnt_d  = {DC_W{1'b0}};
                end
`endif
                default: state_d = ST_IGNORE;
              endcase
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
`ifdef QSPI_SRAM_TARGET_FAST_READ_EN
        ST_DUMMY: begin
          sio_oe_d = 1'b0;
          if (rise_s) begin
            if (dcnt_q == DC_W'(DUMMY_CYCLES - 1)) begin
              state_d = ST_READ;
            end else begin
              dcnt_d = dcnt_q + {{(DC_W-1){1'b0}}, 1'b1};
            end
          end else begin
            dcnt_d = dcnt_q;
          end
        end
`endif
        ST_READ: begin
          if (fall_s) begin
            sio_oe_d = 1'b1;
            if (!half_q) begin
              sio_out_d = rd_byte_s[7:4];
              half_d    = 1'b1;
            end else begin
              sio_out_d = rd_byte_s[3:0];
              half_d    = 1'b0;
              ptr_d     = ptr_inc_s;
            end
          end else begin
            sio_out_d = sio_out_q;
          end
        end
        ST_WRITE: begin
          if (rise_s) begin
            if (!half_q) begin
              wr_hi_d = sio_s2_q;
              half_d  = 1'b1;
            end else begin
              mem_we_s = 1'b1;
              half_d   = 1'b0;
              ptr_d    = ptr_inc_s;
            end
          end else begin
            half_d = half_q;
          end
        end
        ST_IGNORE: sio_oe_d = 1'b0;
        default: begin
          state_d  = ST_IDLE;
          sio_oe_d = 1'b0;
        end
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= {SH_W{1'b0}};
      ptr_q     <= {ADDR_BITS{1'b0}};
      op_q      <= OP_WR;
      half_q    <= 1'b0;
      wr_hi_q   <= 4'h0;
      sio_out_q <= 4'h0;
      sio_oe_q  <= 1'b0;
`ifdef QSPI_SRAM_TARGET_FAST_READ_EN
      dcnt_q    <= {DC_W{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      op_q      <= op_d;
      half_q    <= half_d;
      wr_hi_q   <= wr_hi_d;
      sio_out_q <= sio_out_d;
      sio_oe_q  <= sio_oe_d;
`ifdef QSPI_SRAM_TARGET_FAST_READ_EN
      dcnt_q    <= dcnt_d;
`endif
    end
  end

  // Byte array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[ptr_q] <= mem_wdata_s;
    end
  end

  assign sio_out = sio_out_q;
  assign sio_oe  = sio_oe_q;
  assign busy    = sel_s2_q;

endmodule

// File: tb/tb_qspi_sram_target.sv
// Directed bench for qspi_sram_target: drives the quad-SPI initiator side with SCK half periods of 6 clk.
module tb_qspi_sram_target;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] sio_out;
  logic       sio_oe;
  logic       busy;

  int   total = 0;
  int   bad = 0;
  logic oe_seen = 1'b0;

  always #5 clk = ~clk;

  qspi_sram_target #(.ADDR_BITS(8), .DUMMY_CYCLES(6)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ss_n(ss_n),
    .sio_in(sio_in), .sio_out(sio_out), .sio_oe(sio_oe), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_nib(input logic [3:0] n);
    sio_in = n;
    clk_n(HALF);
    oe_seen = oe_seen | sio_oe;
    sck = 1'b1;
    clk_n(HALF);
    sck = 1'b0;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    tx_nib(b[7:4]);
    tx_nib(b[3:0]);
  endtask

  task automatic rx_check(input string tag, input logic [3:0] exp);
    clk_n(HALF);
    check(tag, {28'h0, sio_out}, {28'h0, exp});
    check({tag, "_oe"}, {31'h0, sio_oe}, 32'h1);
    sck = 1'b1;
    clk_n(HALF);
    sck = 1'b0;
  endtask

  task automatic begin_xfer(input logic [7:0] cmd, input logic [23:0] addr);
    ss_n = 1'b0;
    clk_n(4);
    oe_seen = 1'b0;
    tx_byte(cmd);
    tx_byte(addr[23:16]);
    tx_byte(addr[15:8]);
    tx_byte(addr[7:0]);
  endtask

  task automatic end_xfer();
    clk_n(2);
    ss_n = 1'b1;
    clk_n(8);
  endtask

  initial begin
    clk_n(3);
    check("rst_sio_out", {28'h0, sio_out}, 32'h0);
    check("rst_sio_oe", {31'h0, sio_oe}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    clk_n(3);

    // Write A5 3C at 0x10, then read it back.
    begin_xfer(8'h02, 24'h000010);
    tx_byte(8'hA5);
    tx_byte(8'h3C);
    check("wr_busy", {31'h0, busy}, 32'h1);
    end_xfer();
    begin_xfer(8'h03, 24'h000010);
    check("rd_addr_oe", {31'h0, oe_seen}, 32'h0);
    rx_check("rd10_n0", 4'hA);
    rx_check("rd10_n1", 4'h5);
    rx_check("rd11_n0", 4'h3);
    rx_check("rd11_n1", 4'hC);
    clk_n(2);
    ss_n = 1'b1;
    clk_n(3);
    check("desel_oe", {31'h0, sio_oe}, 32'h0);
    clk_n(6);

    // Top-address write wraps to 0x00.
    begin_xfer(8'h02, 24'h0000FF);
    tx_byte(8'h11);
    tx_byte(8'h22);
    end_xfer();
    begin_xfer(8'h03, 24'h0000FF);
    rx_check("rdff_n0", 4'h1);
    rx_check("rdff_n1", 4'h1);
    rx_check("rdwrap_n0", 4'h2);
    rx_check("rdwrap_n1", 4'h2);
    end_xfer();
    begin_xfer(8'h03, 24'h000000);
    rx_check("rd00_n0", 4'h2);
    rx_check("rd00_n1", 4'h2);
    end_xfer();

    // Partial byte is discarded on deselect.
    begin_xfer(8'h02, 24'h000021);
    tx_byte(8'hB4);
    end_xfer();
    begin_xfer(8'h02, 24'h000020);
    tx_byte(8'h77);
    tx_nib(4'h9);
    end_xfer();
    begin_xfer(8'h03, 24'h000020);
    rx_check("rd20_n0", 4'h7);
    rx_check("rd20_n1", 4'h7);
    rx_check("rd21_n0", 4'hB);
    rx_check("rd21_n1", 4'h4);
    end_xfer();

    // Unknown command is ignored and writes nothing.
    ss_n = 1'b0;
    clk_n(4);
    oe_seen = 1'b0;
    tx_byte(8'h9F);
    for (int i = 0; i < 8; i++) tx_nib(4'(i + 3));
    check("ign_busy", {31'h0, busy}, 32'h1);
    end_xfer();
    check("ign_oe", {31'h0, oe_seen}, 32'h0);
    begin_xfer(8'h03, 24'h000010);
    rx_check("ign_rd_n0", 4'hA);
    rx_check("ign_rd_n1", 4'h5);
    end_xfer();

    // Reset in the middle of a read.
    begin_xfer(8'h03, 24'h000010);
    rx_check("rst_rd_n0", 4'hA);
    clk_n(4);
    check("pre_rst_oe", {31'h0, sio_oe}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", {31'h0, sio_oe}, 32'h0);
    check("mid_rst_out", {28'h0, sio_out}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    clk_n(2);
    ss_n = 1'b1;
    clk_n(2);
    rst_n = 1'b1;
    clk_n(4);
    begin_xfer(8'h03, 24'h000010);
    rx_check("post_rst_n0", 4'hA);
    rx_check("post_rst_n1", 4'h5);
    end_xfer();

    // Fast read.
    begin_xfer(8'hEB, 24'h000010);
`ifdef QSPI_SRAM_TARGET_FAST_READ_EN
    for (int i = 0; i < 6; i++) tx_nib(4'h0);
    check("frd_dummy_oe", {31'h0, oe_seen}, 32'h0);
    rx_check("frd_n0", 4'hA);
    rx_check("frd_n1", 4'h5);
`else
    for (int i = 0; i < 10; i++) tx_nib(4'h0);
    check("frd_off_oe", {31'h0, oe_seen}, 32'h0);
`endif
    end_xfer();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
